// File: rtl/mem_port_arb_pkg.sv
// Shared types and sizing helpers for the two-requester SRAM port arbiter.
package mem_port_arb_pkg;

  typedef enum logic {
    ARB_RUN  = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // Starvation counter width; holds STARVE_MAX values up to 15.
  localparam int unsigned STARVE_W = 4;

  function automatic int unsigned f_bytes_per_word(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned f_log2(input int unsigned v);
    return $clog2(v);
  endfunction

endpackage

// File: rtl/mem_port_arb_prio2.sv
// Two-way fixed-priority pick (requester a preferred) with a starvation
// counter that hands requester b one win after STARVE_MAX consecutive losses.
module arb_prio2
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_a_req,
  input  logic i_b_req,
  input  logic i_block_a,
  output logic o_a_gnt,
  output logic o_b_gnt
);

  logic [STARVE_W-1:0] r_starve_cnt;
  logic                w_b_turn;

  assign w_b_turn = (r_starve_cnt == STARVE_W'(STARVE_MAX));

  always_comb begin
    o_a_gnt = 1'b0;
    o_b_gnt = 1'b0;
    if (i_block_a) begin
      o_b_gnt = i_b_req;
    end else if (i_a_req && i_b_req) begin
      o_b_gnt = w_b_turn;
      o_a_gnt = !w_b_turn;
    end else begin
      o_a_gnt = i_a_req;
      o_b_gnt = i_b_req;
    end
  end

  // Counts only losses; a win, an idle b or a blocked a all restart the run.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (i_b_req && !o_b_gnt) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end else begin
      r_starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// CPU / loader arbiter in front of one single-port synchronous SRAM.
//   state    | meaning
//   ARB_RUN  | shared access, CPU preferred, loader protected from starvation
//   ARB_HOLD | loader-exclusive, CPU never granted
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned AW         = 64,
  parameter int unsigned DW         = 64,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [AW-1:0]              cpu_addr,
  input  logic [DW/8-1:0]            cpu_wstrb,
  input  logic [DW-1:0]              cpu_wdata,
  output logic                       cpu_gnt,
  output logic                       cpu_rvalid,
  output logic [DW-1:0]              cpu_rdata,
  output logic                       cpu_err,
  input  logic                       ext_req,
  input  logic                       ext_we,
  input  logic [AW-1:0]              ext_addr,
  input  logic [DW/8-1:0]            ext_wstrb,
  input  logic [DW-1:0]              ext_wdata,
  output logic                       ext_gnt,
  output logic                       ext_rvalid,
  output logic [DW-1:0]              ext_rdata,
  output logic                       ext_err,
  input  logic                       ext_hold,
  output logic                       hold_ack,
  output logic                       mem_en,
  output logic [DW/8-1:0]            mem_we,
  output logic [$clog2(DEPTH)-1:0]   mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic [DW-1:0]              mem_rdata
);

  localparam int unsigned BPW = f_bytes_per_word(DW);
  localparam int unsigned LSB = f_log2(BPW);
  localparam int unsigned IW  = f_log2(DEPTH);
  localparam logic [AW:0] ADDR_LIM = (AW+1)'(DEPTH * BPW);

  arb_state_e r_state;
  logic       r_hold_ack;
  logic       r_owner_ext;
  logic       r_rd_pend;
  logic       r_oor_pend;
  logic       r_oor_rd;

  logic            w_cpu_req;
  logic            w_ext_req;
  logic            w_block_cpu;
  logic            w_cpu_gnt;
  logic            w_ext_gnt;
  logic            w_any_gnt;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [BPW-1:0]  w_sel_wstrb;
  logic [DW-1:0]   w_sel_wdata;
  logic            w_oor;
  logic            w_mem_en;
  logic            w_rsp_valid;

  // Requests are masked by reset so every output is quiet while it is held.
  assign w_cpu_req   = cpu_req & resetn;
  assign w_ext_req   = ext_req & resetn;
  assign w_block_cpu = (r_state == ARB_HOLD) | ext_hold;

  arb_prio2 #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk       (clk),
    .resetn    (resetn),
    .i_a_req   (w_cpu_req),
    .i_b_req   (w_ext_req),
    .i_block_a (w_block_cpu),
    .o_a_gnt   (w_cpu_gnt),
    .o_b_gnt   (w_ext_gnt)
  );

  assign cpu_gnt = w_cpu_gnt;
  assign ext_gnt = w_ext_gnt;

  assign w_any_gnt   = w_cpu_gnt | w_ext_gnt;
  assign w_sel_we    = w_ext_gnt ? ext_we    : cpu_we;
  assign w_sel_addr  = w_ext_gnt ? ext_addr  : cpu_addr;
  assign w_sel_wstrb = w_ext_gnt ? ext_wstrb : cpu_wstrb;
  assign w_sel_wdata = w_ext_gnt ? ext_wdata : cpu_wdata;

  assign w_oor    = ({1'b0, w_sel_addr} >= ADDR_LIM);
  assign w_mem_en = w_any_gnt & ~w_oor;

  assign mem_en    = w_mem_en;
  assign mem_we    = (w_mem_en && w_sel_we) ? w_sel_wstrb : '0;
  assign mem_addr  = w_mem_en ? w_sel_addr[LSB +: IW] : '0;
  assign mem_wdata = (w_mem_en && w_sel_we) ? w_sel_wdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ARB_RUN;
      r_hold_ack <= 1'b0;
    end else begin
      case (r_state)
        ARB_RUN: begin
          if (ext_hold) begin
            r_state    <= ARB_HOLD;
            r_hold_ack <= 1'b1;
          end
        end
        ARB_HOLD: begin
          if (!ext_hold) begin
            r_state    <= ARB_RUN;
            r_hold_ack <= 1'b0;
          end
        end
        default: begin
          r_state    <= ARB_RUN;
          r_hold_ack <= 1'b0;
        end
      endcase
    end
  end

  assign hold_ack = r_hold_ack;

  // One-deep response pipe; SRAM data arrives the cycle after the grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner_ext <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_oor_pend  <= 1'b0;
      r_oor_rd    <= 1'b0;
    end else begin
      r_rd_pend  <= w_mem_en & ~w_sel_we;
      r_oor_pend <= w_any_gnt & w_oor;
      r_oor_rd   <= w_any_gnt & w_oor & ~w_sel_we;
      if (w_any_gnt) begin
        r_owner_ext <= w_ext_gnt;
      end
    end
  end

  assign w_rsp_valid = r_rd_pend | r_oor_rd;

  assign cpu_rvalid = w_rsp_valid & ~r_owner_ext;
  assign ext_rvalid = w_rsp_valid &  r_owner_ext;
  assign cpu_rdata  = (r_rd_pend && !r_owner_ext) ? mem_rdata : '0;
  assign ext_rdata  = (r_rd_pend &&  r_owner_ext) ? mem_rdata : '0;
  assign cpu_err    = r_oor_pend & ~r_owner_ext;
  assign ext_err    = r_oor_pend &  r_owner_ext;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: an SRAM model, a cycle-level reference of
// the arbitration rules checked every cycle, and hand-computed spot checks.
module tb_mem_port_arb;

  localparam int AW = 64, DW = 64, DEPTH = 1024, SMAX = 4, BPW = 8;
  localparam logic [63:0] LIMIT = 64'(DEPTH * BPW);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0, ext_hold = 0;
  logic [AW-1:0] cpu_addr = '0, ext_addr = '0;
  logic [7:0] cpu_wstrb = '0, ext_wstrb = '0;
  logic [DW-1:0] cpu_wdata = '0, ext_wdata = '0;
  logic cpu_gnt, cpu_rvalid, cpu_err, ext_gnt, ext_rvalid, ext_err, hold_ack, mem_en;
  logic [DW-1:0] cpu_rdata, ext_rdata, mem_wdata;
  logic [7:0] mem_we;
  logic [9:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  logic [63:0] sram [DEPTH];
  logic [63:0] gold [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wstrb(cpu_wstrb),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wstrb(ext_wstrb),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata), .ext_err(ext_err),
    .ext_hold(ext_hold), .hold_ack(hold_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_word(input int i);
    if (i == 1) return 64'hFFFF_FFFF_FFFF_FFFF;
    if (i == 2) return 64'hDEAD_BEEF_0123_4567;
    return {32'hC0DE_0000 | 32'(i), 32'(i) * 32'h0101_0101};
  endfunction

  // Synchronous single-port SRAM: write bytes or register a read word.
  always @(posedge clk) begin
    logic [63:0] w;
    if (mem_en) begin
      if (mem_we != 8'h00) begin
        w = sram[mem_addr];
        for (int b = 0; b < BPW; b++)
          if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        sram[mem_addr] = w;
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // Reference model state
  bit          m_hold, m_blocked, eg_c, eg_e, m_oor, m_en;
  int          m_starve;
  bit          p_rd, p_err, p_ext;
  logic [63:0] p_data, m_addr, m_wdata;
  logic [7:0]  m_wstrb;
  bit          m_we;
  int          m_idx;

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_gnt", {62'd0, cpu_gnt, ext_gnt}, 64'd0);
      chk("rst_flags", {59'd0, cpu_rvalid, ext_rvalid, cpu_err, ext_err, hold_ack}, 64'd0);
      chk("rst_cpu_rdata", cpu_rdata, 64'd0);
      chk("rst_ext_rdata", ext_rdata, 64'd0);
      chk("rst_mem_ctl", {55'd0, mem_en, mem_we}, 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", mem_wdata, 64'd0);
      m_hold = 0; m_starve = 0; p_rd = 0; p_err = 0; p_ext = 0; p_data = '0;
    end else begin
      m_blocked = m_hold || ext_hold;
      if (m_blocked) begin
        eg_c = 0; eg_e = ext_req;
      end else if (cpu_req && ext_req) begin
        eg_e = (m_starve == SMAX); eg_c = !eg_e;
      end else begin
        eg_c = cpu_req; eg_e = ext_req;
      end
      chk("cpu_gnt", 64'(cpu_gnt), 64'(eg_c));
      chk("ext_gnt", 64'(ext_gnt), 64'(eg_e));
      chk("hold_ack", 64'(hold_ack), 64'(m_hold));

      chk("cpu_rvalid", 64'(cpu_rvalid), 64'((p_rd || p_err) && !p_ext && p_rd));
      chk("ext_rvalid", 64'(ext_rvalid), 64'(p_rd && p_ext));
      chk("cpu_rdata", cpu_rdata, (p_rd && !p_ext) ? p_data : 64'd0);
      chk("ext_rdata", ext_rdata, (p_rd && p_ext) ? p_data : 64'd0);
      chk("cpu_err", 64'(cpu_err), 64'(p_err && !p_ext));
      chk("ext_err", 64'(ext_err), 64'(p_err && p_ext));

      m_we    = eg_e ? ext_we    : cpu_we;
      m_addr  = eg_e ? ext_addr  : cpu_addr;
      m_wstrb = eg_e ? ext_wstrb : cpu_wstrb;
      m_wdata = eg_e ? ext_wdata : cpu_wdata;
      m_oor   = (m_addr >= LIMIT);
      m_en    = (eg_c || eg_e) && !m_oor;
      chk("mem_en", 64'(mem_en), 64'(m_en));
      if (m_en) begin
        m_idx = int'(m_addr / BPW);
        chk("mem_addr", 64'(mem_addr), 64'(m_idx));
        chk("mem_we", 64'(mem_we), m_we ? 64'(m_wstrb) : 64'd0);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end

      // Outstanding read data is 0 for out-of-range reads; a read of the
      // freshly written word sees the merged bytes.
      p_rd   = (eg_c || eg_e) && !m_we;
      p_err  = (eg_c || eg_e) && m_oor;
      p_ext  = eg_e;
      p_data = (p_rd && !m_oor) ? gold[m_idx] : 64'd0;
      if (m_en && m_we)
        for (int b = 0; b < BPW; b++)
          if (m_wstrb[b]) gold[m_idx][8*b +: 8] = m_wdata[8*b +: 8];
      if (m_blocked || !ext_req || eg_e) m_starve = 0;
      else m_starve = m_starve + 1;
      m_hold = ext_hold;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] seq;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = init_word(i);
      gold[i] = init_word(i);
    end
    repeat (3) step();
    resetn = 1;

    // CPU read of word 2
    cpu_req = 1; cpu_we = 0; cpu_addr = 64'h10;
    @(negedge clk);
    chk("t1_gnt", 64'(cpu_gnt), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'd2);
    step(); cpu_req = 0;
    @(negedge clk);
    chk("t1_rvalid", 64'(cpu_rvalid), 64'd1);
    chk("t1_rdata", cpu_rdata, 64'hDEAD_BEEF_0123_4567);
    chk("t1_ext_rvalid", 64'(ext_rvalid), 64'd0);

    // Byte-strobe write then readback
    step(); cpu_req = 1; cpu_we = 1; cpu_addr = 64'h8; cpu_wstrb = 8'h0F;
    cpu_wdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    chk("t2_mem_we", 64'(mem_we), 64'h0F);
    step(); cpu_we = 0;
    @(negedge clk);
    step(); cpu_req = 0;
    @(negedge clk);
    chk("t2_readback", cpu_rdata, 64'hFFFF_FFFF_3333_4444);

    // Starvation: both request continuously
    step(); cpu_req = 1; cpu_we = 0; cpu_addr = 64'h18;
    ext_req = 1; ext_we = 0; ext_addr = 64'h20;
    seq = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      seq = {seq[5:0], ext_gnt};
      step();
    end
    chk("t3_grant_seq", 64'(seq), 64'(7'b0000100));
    cpu_req = 0; ext_req = 0;

    // HOLD entry while CPU reads every cycle
    step(); cpu_req = 1; cpu_we = 0; cpu_addr = 64'h28;
    @(negedge clk);
    chk("t4_pre_gnt", 64'(cpu_gnt), 64'd1);
    step(); ext_hold = 1;
    @(negedge clk);
    chk("t4_trans_gnt", 64'(cpu_gnt), 64'd0);
    chk("t4_inflight_rvalid", 64'(cpu_rvalid), 64'd1);
    chk("t4_trans_ack", 64'(hold_ack), 64'd0);
    step();
    @(negedge clk);
    chk("t4_hold_ack", 64'(hold_ack), 64'd1);
    chk("t4_hold_gnt", 64'(cpu_gnt), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step(); ext_req = 1; ext_we = 1; ext_addr = 64'h40 + 64'(8 * i);
      ext_wstrb = 8'hFF; ext_wdata = 64'hA5A5_0000_0000_0000 | 64'(i);
      @(negedge clk);
      chk("t4_ext_wr_gnt", 64'(ext_gnt), 64'd1);
    end
    step(); ext_req = 0; ext_hold = 0;
    @(negedge clk);
    chk("t4_exit_gnt", 64'(cpu_gnt), 64'd0);
    chk("t4_exit_ack", 64'(hold_ack), 64'd1);
    step();
    @(negedge clk);
    chk("t4_run_gnt", 64'(cpu_gnt), 64'd1);
    chk("t4_run_ack", 64'(hold_ack), 64'd0);
    step(); cpu_req = 0; ext_req = 1; ext_we = 0; ext_addr = 64'h40;
    @(negedge clk);
    step(); ext_req = 0;
    @(negedge clk);
    chk("t4_ext_rvalid", 64'(ext_rvalid), 64'd1);
    chk("t4_ext_rdata", ext_rdata, 64'hA5A5_0000_0000_0000);

    // Out-of-range read and write; last in-range word
    step(); cpu_req = 1; cpu_we = 0; cpu_addr = 64'h2000;
    @(negedge clk);
    chk("t5_gnt", 64'(cpu_gnt), 64'd1);
    chk("t5_mem_en", 64'(mem_en), 64'd0);
    step(); cpu_req = 0; ext_req = 1; ext_we = 1; ext_addr = 64'hFFFF_0000_0000_0000;
    ext_wstrb = 8'hFF;
    @(negedge clk);
    chk("t5_err", 64'(cpu_err), 64'd1);
    chk("t5_rvalid", 64'(cpu_rvalid), 64'd1);
    chk("t5_rdata", cpu_rdata, 64'd0);
    step(); ext_req = 0;
    @(negedge clk);
    chk("t5_ext_err", 64'(ext_err), 64'd1);
    chk("t5_ext_rvalid", 64'(ext_rvalid), 64'd0);
    step(); cpu_req = 1; cpu_addr = 64'h1FF8;
    @(negedge clk);
    chk("t5_last_en", 64'(mem_en), 64'd1);
    chk("t5_last_addr", 64'(mem_addr), 64'd1023);
    step(); cpu_req = 0;

    // Reset right after a granted read
    step(); cpu_req = 1; cpu_we = 0; cpu_addr = 64'h10;
    @(negedge clk);
    chk("t6_gnt", 64'(cpu_gnt), 64'd1);
    step(); resetn = 0;
    @(negedge clk);
    chk("t6_rst_rvalid", 64'(cpu_rvalid), 64'd0);
    chk("t6_rst_gnt", 64'(cpu_gnt), 64'd0);
    step(); cpu_req = 0;
    step(); resetn = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_post_rvalid", 64'(cpu_rvalid), 64'd0);
      step();
    end
    cpu_req = 1; cpu_addr = 64'h10;
    @(negedge clk);
    step(); cpu_req = 0;
    @(negedge clk);
    chk("t6_after_rdata", cpu_rdata, 64'hDEAD_BEEF_0123_4567);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
